// File: rtl/intr_ctrl.sv
// Fixed-priority interrupt controller: edge-captured pending bits, mask, REQ/ack/EOI handshake, per-source clear pulse.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on every irq_src bit ahead of edge detection.
module intr_ctrl #(
    parameter int NSRC   = 4,
    parameter int VECWID = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              cs,
    input  logic              wr,
    input  logic              rd,
    input  logic [1:0]        addr,
    input  logic [7:0]        datain,
    output logic [7:0]        dataout,
    output logic              irq_out,
    output logic [VECWID-1:0] vector,
    input  logic              irq_ack,
    output logic [NSRC-1:0]   clr_flag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t            state_q;
    logic [NSRC-1:0]   src_in;
    logic [NSRC-1:0]   src_q;
    logic [NSRC-1:0]   rise;
    logic [NSRC-1:0]   pending_q;
    logic [NSRC-1:0]   pending_d;
    logic [NSRC-1:0]   mask_q;
    logic [NSRC-1:0]   cand;
    logic [NSRC-1:0]   vec_oh;
    logic [VECWID-1:0] win;
    logic [VECWID-1:0] vector_q;
    logic [NSRC-1:0]   clr_flag_q;
    logic [7:0]        dataout_q;
    logic [7:0]        rd_data;
    logic              irq_out_q;
    logic              in_service_q;
    logic              wr_mask;
    logic              wr_pend;
    logic              wr_eoi;
    logic              req_live;
    logic              ack_ok;
    logic              unused_datain;

`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] sync1_q;
    logic [NSRC-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = irq_src;
`endif

    assign rise    = src_in & ~src_q;
    assign cand    = pending_q & mask_q;
    assign wr_mask = cs & wr & (addr == 2'd0);
    assign wr_pend = cs & wr & (addr == 2'd1);
    assign wr_eoi  = cs & wr & (addr == 2'd3);

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_vec_oh
        assign vec_oh[gi] = (vector_q == VECWID'(gi));
    end

    // The request stays alive only while its source is still pending and enabled.
    assign req_live = |(pending_q & mask_q & vec_oh);
    assign ack_ok   = (state_q == ST_REQ) & req_live & irq_ack;

    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win = VECWID'(i);
            end
        end
    end

    // Clears first, then new edges: a fresh rising edge always survives.
    always_comb begin
        pending_d = pending_q;
        if (wr_pend) begin
            pending_d = pending_d & ~datain[NSRC-1:0];
        end
        if (ack_ok) begin
            pending_d = pending_d & ~vec_oh;
        end
        pending_d = pending_d | rise;
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0: rd_data[NSRC-1:0] = mask_q;
            2'd1: rd_data[NSRC-1:0] = pending_q;
            2'd2: begin
                rd_data[VECWID-1:0] = vector_q;
                rd_data[6]          = irq_out_q;
                rd_data[7]          = in_service_q;
            end
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            dataout_q <= '0;
        end else begin
            src_q     <= src_in;
            pending_q <= pending_d;
            if (wr_mask) begin
                mask_q <= datain[NSRC-1:0];
            end
            if (cs & rd) begin
                dataout_q <= rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            irq_out_q    <= 1'b0;
            vector_q     <= '0;
            clr_flag_q   <= '0;
            in_service_q <= 1'b0;
        end else begin
            clr_flag_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|cand) begin
                        vector_q  <= win;
                        irq_out_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!req_live) begin
                        irq_out_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (irq_ack) begin
                        irq_out_q    <= 1'b0;
                        clr_flag_q   <= vec_oh;
                        in_service_q <= 1'b1;
                        state_q      <= ST_SERV;
                    end
                end
                ST_SERV: begin
                    if (wr_eoi) begin
                        in_service_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    irq_out_q    <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign unused_datain = ^datain;

    assign dataout  = dataout_q;
    assign irq_out  = irq_out_q;
    assign vector   = vector_q;
    assign clr_flag = clr_flag_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl (default build, no input synchronizer).
module tb_intr_ctrl;

    localparam int NSRC   = 4;
    localparam int VECWID = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NSRC-1:0]   irq_src;
    logic              cs;
    logic              wr;
    logic              rd;
    logic [1:0]        addr;
    logic [7:0]        datain;
    logic [7:0]        dataout;
    logic              irq_out;
    logic [VECWID-1:0] vector;
    logic              irq_ack;
    logic [NSRC-1:0]   clr_flag;

    int total = 0;
    int bad   = 0;
    logic [7:0] d;

    always #5 clk = ~clk;

    intr_ctrl #(.NSRC(NSRC), .VECWID(VECWID)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_src  (irq_src),
        .cs       (cs),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .datain   (datain),
        .dataout  (dataout),
        .irq_out  (irq_out),
        .vector   (vector),
        .irq_ack  (irq_ack),
        .clr_flag (clr_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [7:0] v);
        cs = 1'b1; wr = 1'b1; addr = a; datain = v;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [7:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        cs = 1'b0; rd = 1'b0;
        v = dataout;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_src = '0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = '0; datain = '0; irq_ack = 1'b0;
        #23;
        check("rst irq_out", 32'(irq_out), 0);
        check("rst vector", 32'(vector), 0);
        check("rst clr_flag", 32'(clr_flag), 0);
        check("rst dataout", 32'(dataout), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reg_rd(2'd0, d); check("rst MASK", 32'(d), 0);
        reg_rd(2'd1, d); check("rst PEND", 32'(d), 0);

        // Single source, latency and handshake
        reg_wr(2'd0, 8'h01);
        irq_src = 4'b0001;
        tick(); check("t1 irq N+1", 32'(irq_out), 0);
        tick(); check("t1 irq N+2", 32'(irq_out), 1);
        check("t1 vector", 32'(vector), 0);
        reg_rd(2'd1, d); check("t1 PEND", 32'(d), 32'h01);
        reg_rd(2'd2, d); check("t1 STAT req", 32'(d), 32'h40);
        ack();
        check("t1 irq A+1", 32'(irq_out), 0);
        check("t1 clr A+1", 32'(clr_flag), 32'h1);
        tick(); check("t1 clr A+2", 32'(clr_flag), 0);
        irq_src = 4'b0000;
        reg_rd(2'd1, d); check("t1 PEND after ack", 32'(d), 0);
        reg_rd(2'd2, d); check("t1 STAT serv", 32'(d), 32'h80);
        reg_wr(2'd3, 8'h00);
        check("t1 irq after EOI", 32'(irq_out), 0);
        reg_rd(2'd2, d); check("t1 STAT idle", 32'(d), 32'h00);

        // Two simultaneous edges, priority and re-request after EOI
        reg_wr(2'd0, 8'h0f);
        irq_src = 4'b0110;
        tick(); tick();
        check("t2 irq", 32'(irq_out), 1);
        check("t2 vector first", 32'(vector), 1);
        ack(); check("t2 clr src1", 32'(clr_flag), 32'h2);
        tick();
        reg_wr(2'd3, 8'h00);
        check("t2 irq E+1", 32'(irq_out), 0);
        tick();
        check("t2 irq E+2", 32'(irq_out), 1);
        check("t2 vector second", 32'(vector), 2);
        ack(); check("t2 clr src2", 32'(clr_flag), 32'h4);
        irq_src = 4'b0000;
        reg_wr(2'd3, 8'h00);

        // Vector 3 ack: one-cycle clear pulse, STAT in service
        irq_src = 4'b1000;
        tick(); tick();
        check("t3 irq", 32'(irq_out), 1);
        check("t3 vector", 32'(vector), 3);
        ack(); check("t3 clr A+1", 32'(clr_flag), 32'h8);
        tick(); check("t3 clr A+2", 32'(clr_flag), 0);
        irq_src = 4'b0000;
        reg_rd(2'd1, d); check("t3 PEND", 32'(d), 0);
        reg_rd(2'd2, d); check("t3 STAT", 32'(d), 32'h83);
        reg_wr(2'd3, 8'h00);

        // Masked source accumulates but does not request; stray ack ignored
        reg_wr(2'd0, 8'h00);
        irq_src = 4'b0100;
        repeat (4) tick();
        check("t4 masked irq", 32'(irq_out), 0);
        ack(); check("t4 stray ack clr", 32'(clr_flag), 0);
        reg_rd(2'd1, d); check("t4 PEND masked", 32'(d), 32'h04);
        reg_wr(2'd0, 8'h04);
        tick();
        check("t4 irq after unmask", 32'(irq_out), 1);
        check("t4 vector", 32'(vector), 2);
        ack();
        irq_src = 4'b0000;
        tick();
        reg_wr(2'd3, 8'h00);

        // W1C vs same-cycle edge, then software clear while requesting
        reg_wr(2'd0, 8'h02);
        irq_src = 4'b0010;
        cs = 1'b1; wr = 1'b1; addr = 2'd1; datain = 8'h02;
        tick();
        cs = 1'b0; wr = 1'b0;
        reg_rd(2'd1, d); check("t5 PEND set wins", 32'(d), 32'h02);
        check("t5 irq", 32'(irq_out), 1);
        check("t5 vector", 32'(vector), 1);
        reg_wr(2'd1, 8'h02);
        check("t5 clr W+1", 32'(clr_flag), 0);
        tick();
        check("t5 irq dropped", 32'(irq_out), 0);
        check("t5 clr W+2", 32'(clr_flag), 0);
        tick();
        check("t5 irq stays low", 32'(irq_out), 0);
        reg_rd(2'd1, d); check("t5 PEND cleared", 32'(d), 0);
        irq_src = 4'b0000;
        tick();

        // Asynchronous reset while requesting
        irq_src = 4'b0010;
        tick(); tick();
        check("t6 irq before rst", 32'(irq_out), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst REQ irq", 32'(irq_out), 0);
        check("t6 rst REQ vector", 32'(vector), 0);
        irq_src = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Asynchronous reset while in service
        reg_wr(2'd0, 8'h02);
        tick();
        irq_src = 4'b0010;
        tick(); tick();
        check("t6 irq", 32'(irq_out), 1);
        ack(); check("t6 clr", 32'(clr_flag), 32'h2);
        reg_rd(2'd2, d); check("t6 STAT serv", 32'(d), 32'h81);
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst dataout", 32'(dataout), 0);
        check("t6 rst irq", 32'(irq_out), 0);
        check("t6 rst vector", 32'(vector), 0);
        check("t6 rst clr", 32'(clr_flag), 0);
        irq_src = 4'b0000;
        @(posedge clk); #1;
        rst_n = 1'b1;
        reg_wr(2'd3, 8'h00);
        tick();
        check("t6 irq after EOI", 32'(irq_out), 0);
        reg_rd(2'd2, d); check("t6 STAT idle", 32'(d), 0);
        reg_rd(2'd0, d); check("t6 MASK reset", 32'(d), 0);
        reg_rd(2'd1, d); check("t6 PEND reset", 32'(d), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller sitting directly downstream of the MCU timer and other peripheral interrupt sources. It captures rising edges on source request lines into pending bits, applies a software mask, and arbitrates by fixed priority. It presents one request and a vector to the CPU, completes an ack/EOI handshake, and pulses a per-source clear back to the originating peripheral (for example, the timer's `clearFlag` input).

## Interface
- `NSRC`, 4: number of interrupt sources, 1..8.
- `VECWID`, 3: vector width; `2**VECWID >= NSRC`.

- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `irq_src` in NSRC: request lines (for example, timer `intrup`); bit 0 has the highest priority.
- `cs` in 1: register select.
- `wr` in 1: register write strobe, qualified by `cs`.
- `rd` in 1: register read strobe, qualified by `cs`.
- `addr` in 2: register address.
- `datain` in 8: write data.
- `dataout` out 8: registered read data.
- `irq_out` out 1: interrupt request to the CPU.
- `vector` out VECWID: index of the source being requested or serviced.
- `irq_ack` in 1: CPU acknowledge; single-cycle pulse.
- `clr_flag` out NSRC: one-cycle clear pulse per source.

## Operation
- Edge detect:
  - `src_q` holds the previous `irq_src`.
  - `rise = irq_src & ~src_q` sets `pending[i]`.
- Registers:
  - addr 0 MASK (R/W): 1 = enabled. Reset value 0.
  - addr 1 PEND: reads `pending`; a write is write-1-to-clear.
  - addr 2 STAT (RO): {`in_service`, `irq_out`, zero pad, `vector`}, with `vector` in the low bits.
  - addr 3 EOI (WO): any write ends service.
- Register access:
  - Reads: when `cs&rd`, `dataout <= reg[addr]`; otherwise `dataout` holds its value. Unused high bits read 0.
- `cand = pending & mask`. The winner is the lowest set index.
- FSM states IDLE, REQ, SERV:
  - IDLE: if `cand != 0`, latch `vector` = winner and go to REQ.
  - REQ: `irq_out = 1`.
    - On `irq_ack`: clear `pending[vector]`, pulse `clr_flag[vector]` for 1 cycle, go to SERV.
    - If `pending[vector]` is cleared by software or masked before ack: drop to IDLE with no `clr_flag`.
  - SERV: `in_service = 1`; no new request is issued. An EOI write returns to IDLE.
- `vector` is frozen from REQ entry until IDLE is re-entered.
- Simultaneous events:
  - A rising edge and a W1C on the same bit in the same cycle: the set wins.
  - A rising edge on the vectored source in the ack cycle: the bit ends set, and `clr_flag` still pulses.
  - EOI written while in IDLE or REQ: ignored.
  - `irq_ack` outside REQ: ignored.
- Masked sources still accumulate pending bits.

## Timing
- Reset values:
  - `dataout` = 0, `irq_out` = 0, `vector` = 0, `clr_flag` = 0.
  - MASK = 0, `pending` = 0, `src_q` = 0, state IDLE.
- Reset mid-service drops `irq_out` immediately. Pending edges are lost.
- Latency (without the synchronizer):
  - Edge at cycle N: `pending` set at N+1.
  - State REQ / `irq_out` high at N+2.
- `irq_ack` at cycle A:
  - `irq_out` low and `clr_flag` high at A+1.
  - `clr_flag` low at A+2.
- An EOI write at cycle E returns to IDLE at E+1. If another source is pending, `irq_out` is high again at E+2.
- A read returns data one cycle after `cs&rd`.

## Configuration
- `INTC_SYNC_EN` defined:
  - Each `irq_src` bit passes through a 2-flop synchronizer (reset to 0) before edge detection.
  - Edge-to-`irq_out` latency becomes 4 cycles.
- `INTC_SYNC_EN` undefined: `irq_src` is taken as synchronous to `clk`; latency is 2 cycles.

## Test plan
- Reset, then MASK=0x1 and a rising edge on `irq_src[0]` -> PEND reads 0x1, `irq_out` high 2 cycles after the edge, `vector` = 0.
- Edges on src 2 and src 1 in the same cycle, MASK=0xF -> `vector` = 1 first. After ack and EOI, `vector` = 2 and `irq_out` re-asserts at E+2.
- `irq_ack` in REQ with `vector` = 3 -> `clr_flag` = 4'b1000 for exactly 1 cycle, PEND bit 3 = 0, STAT shows `in_service`.
- Source pending with MASK=0 -> no `irq_out`. Then write MASK=0x4 -> `irq_out` high.
- Write PEND=0x2 in the same cycle as a rising edge on src 1 -> PEND reads 0x2. Write PEND=0x2 in REQ (vector 1) -> back to IDLE, `irq_out` low, no `clr_flag`.
- Assert `rst_n`=0 while in SERV -> all outputs 0 asynchronously. After release, EOI is ignored and the state is IDLE.
